// File: rtl/route_ring.sv
// N-stage register ring with hold/rotate/LFSR/load modes, loop-integrity check and cycle counter.
// Optional parity output and rotate-mode parity check enabled by defining ROUTE_RING_PARITY_EN.
module route_ring #(
  parameter int                STAGES = 8,
  parameter logic [STAGES-1:0] SEED   = STAGES'(1),
  parameter logic [STAGES-1:0] TAPS   = STAGES'(8'hB8),
  parameter int                CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              LSR,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [STAGES-1:0] load_val,
  output logic [STAGES-1:0] q,
  output logic              period_ok,
  output logic              err,
`ifdef ROUTE_RING_PARITY_EN
  output logic              parity,
`endif
  output logic [CNT_W-1:0]  cycles
);

  localparam logic [1:0] M_HOLD = 2'd0;
  localparam logic [1:0] M_ROT  = 2'd1;
  localparam logic [1:0] M_LFSR = 2'd2;
  localparam logic [1:0] M_LOAD = 2'd3;

  localparam int              POS_W    = $clog2(STAGES);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(STAGES - 1);

  logic [STAGES-1:0] ref_q;
  logic [POS_W-1:0]  pos;
  logic [1:0]        prev_mode;

  logic [STAGES-1:0] q_next;
  logic              lockup;
  logic              mode_chg;
  logic              rot_steady;
  logic              rot_chk;
  logic              period_hit;

  always_comb begin
    q_next = q;
    lockup = 1'b0;
    case (mode)
      M_ROT:  q_next = {q[STAGES-2:0], q[STAGES-1]};
      M_LFSR: begin
        // An all-zero LFSR would never leave zero; reseed and flag it.
        if (q == '0) begin
          q_next = SEED;
          lockup = 1'b1;
        end else begin
          q_next = {q[STAGES-2:0], ^(q & TAPS)};
        end
      end
      M_LOAD: q_next = load_val;
      default: q_next = q;
    endcase
  end

  assign mode_chg   = (mode != prev_mode);
  assign rot_steady = (mode == M_ROT) && !mode_chg;
  assign rot_chk    = rot_steady && (pos == POS_LAST);
  assign period_hit = rot_chk && (q_next == ref_q);

`ifdef ROUTE_RING_PARITY_EN
  logic par_next;
  logic par_err;
  assign par_next = ^q_next;
  assign par_err  = rot_steady && (par_next != parity);
`endif

  always_ff @(posedge CLK) begin
    if (LSR) begin
      q         <= SEED;
      ref_q     <= SEED;
      pos       <= '0;
      prev_mode <= M_HOLD;
      period_ok <= 1'b0;
      err       <= 1'b0;
      cycles    <= '0;
`ifdef ROUTE_RING_PARITY_EN
      parity    <= ^SEED;
`endif
    end else begin
      period_ok <= 1'b0;
      if (en) begin
        q         <= q_next;
        prev_mode <= mode;
        if (cycles != '1) cycles <= cycles + 1'b1;
        if (mode == M_LOAD) begin
          ref_q <= load_val;
          pos   <= '0;
        end else if (mode_chg) begin
          // Entering rotate: this cycle's rotate is the first one counted against ref_q.
          ref_q <= q;
          pos   <= (mode == M_ROT) ? POS_W'(1) : '0;
        end else if (mode == M_ROT) begin
          pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
          if (rot_chk) begin
            period_ok <= period_hit;
            if (!period_hit) err <= 1'b1;
          end
        end
        if (lockup) err <= 1'b1;
`ifdef ROUTE_RING_PARITY_EN
        parity <= par_next;
        if (par_err) err <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_route_ring.sv
// Self-checking bench for route_ring: directed scenarios plus randomized traffic against a reference model.
module tb_route_ring;

  localparam int         S      = 8;
  localparam logic [7:0] SEED_V = 8'h01;
  localparam logic [7:0] TAPS_V = 8'hB8;

  logic       CLK = 1'b0;
  logic       LSR = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] load_val = 8'h00;

  logic [7:0]  q, q4;
  logic        period_ok, period_ok4, err, err4;
  logic [15:0] cycles;
  logic [3:0]  cycles4;
`ifdef ROUTE_RING_PARITY_EN
  logic parity, parity4;
`endif

  route_ring #(.STAGES(S), .SEED(SEED_V), .TAPS(TAPS_V), .CNT_W(16)) dut (
    .CLK(CLK), .LSR(LSR), .en(en), .mode(mode), .load_val(load_val),
    .q(q), .period_ok(period_ok), .err(err),
`ifdef ROUTE_RING_PARITY_EN
    .parity(parity),
`endif
    .cycles(cycles));

  route_ring #(.STAGES(S), .SEED(SEED_V), .TAPS(TAPS_V), .CNT_W(4)) dut4 (
    .CLK(CLK), .LSR(LSR), .en(en), .mode(mode), .load_val(load_val),
    .q(q4), .period_ok(period_ok4), .err(err4),
`ifdef ROUTE_RING_PARITY_EN
    .parity(parity4),
`endif
    .cycles(cycles4));

  always #5 CLK = ~CLK;

  // Reference model state: rot_cnt is the number of rotates performed since ref was taken.
  logic [7:0] m_q, m_ref;
  int         rot_cnt;
  logic [1:0] m_prev;
  logic       m_per, m_err;
  int         m_cyc;

  int total  = 0;
  int passed = 0;
  int pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    int fb = 0;
    for (int i = 0; i < S; i++)
      if (TAPS_V[i]) fb ^= int'(v[i]);
    return 8'(({24'd0, v} << 1) | 32'(fb));
  endfunction

  task automatic model_update();
    logic [7:0] nq;
    if (LSR) begin
      m_q = SEED_V; m_ref = SEED_V; rot_cnt = 0; m_prev = 2'd0;
      m_per = 1'b0; m_err = 1'b0; m_cyc = 0;
    end else if (!en) begin
      m_per = 1'b0;
    end else begin
      m_per = 1'b0;
      nq = m_q;
      case (mode)
        2'd1: nq = 8'((32'(m_q) * 2) % 256 + 32'(m_q) / 128);
        2'd2: begin
          if (m_q == 8'h00) begin nq = SEED_V; m_err = 1'b1; end
          else nq = lfsr_next(m_q);
        end
        2'd3: nq = load_val;
        default: nq = m_q;
      endcase
      if (mode == 2'd3) begin
        m_ref = load_val; rot_cnt = 0;
      end else if (mode != m_prev) begin
        m_ref = m_q; rot_cnt = (mode == 2'd1) ? 1 : 0;
      end else if (mode == 2'd1) begin
        rot_cnt++;
        if (rot_cnt % S == 0) begin
          if (nq == m_ref) m_per = 1'b1;
          else m_err = 1'b1;
        end
      end
      if (m_cyc < 65535) m_cyc++;
      m_prev = mode;
      m_q = nq;
    end
  endtask

  task automatic check_all();
    chk("q", 32'(q), 32'(m_q));
    chk("period_ok", 32'(period_ok), 32'(m_per));
    chk("err", 32'(err), 32'(m_err));
    chk("cycles", 32'(cycles), 32'(m_cyc));
    chk("q_cnt4", 32'(q4), 32'(m_q));
    chk("period_ok_cnt4", 32'(period_ok4), 32'(m_per));
    chk("err_cnt4", 32'(err4), 32'(m_err));
    chk("cycles_cnt4", 32'(cycles4), 32'((m_cyc > 15) ? 15 : m_cyc));
`ifdef ROUTE_RING_PARITY_EN
    chk("parity", 32'(parity), 32'(^m_q));
    chk("parity_cnt4", 32'(parity4), 32'(^m_q));
`endif
    if (period_ok === 1'b1) pulses++;
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [7:0] lv);
    LSR = r; en = e; mode = m; load_val = lv;
    @(posedge CLK);
    model_update();
    #1;
    check_all();
  endtask

  task automatic run(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, m, 8'h00);
  endtask

  initial begin
    logic [1:0] rm;
    logic [7:0] lfsr_first;
    // Reset state
    step(1'b1, 1'b0, 2'd0, 8'h00);
    step(1'b1, 1'b1, 2'd1, 8'hFF);
    chk("reset_q", 32'(q), 32'h01);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_cycles", 32'(cycles), 32'h0);
    chk("reset_period_ok", 32'(period_ok), 32'h0);

    // Rotate from reset: one pulse as q returns home
    pulses = 0;
    run(7, 2'd1);
    chk("rot_q_at7", 32'(q), 32'h80);
    run(1, 2'd1);
    chk("rot_home_q", 32'(q), 32'h01);
    chk("rot_home_pulse", 32'(period_ok), 32'h1);
    run(1, 2'd1);
    chk("rot_pulse_count", 32'(pulses), 32'd1);
    chk("rot_err", 32'(err), 32'h0);

    // Load A5 then rotate 16: two pulses
    step(1'b0, 1'b1, 2'd3, 8'hA5);
    pulses = 0;
    run(8, 2'd1);
    chk("load_rot8_q", 32'(q), 32'hA5);
    run(8, 2'd1);
    chk("load_rot16_q", 32'(q), 32'hA5);
    chk("load_rot_pulses", 32'(pulses), 32'd2);

    // Load zero and rotate: still a clean period
    step(1'b0, 1'b1, 2'd3, 8'h00);
    run(8, 2'd1);
    chk("zero_rot_pulse", 32'(period_ok), 32'h1);

    // LFSR full period from SEED
    step(1'b1, 1'b1, 2'd0, 8'h00);
    run(1, 2'd2);
    lfsr_first = q;
    chk("lfsr_first", 32'(lfsr_first), 32'h02);
    run(254, 2'd2);
    chk("lfsr_period_q", 32'(q), 32'h01);
    chk("lfsr_no_err", 32'(err), 32'h0);
    chk("cnt4_saturated", 32'(cycles4), 32'd15);

    // Lockup recovery and sticky err
    step(1'b0, 1'b1, 2'd3, 8'h00);
    run(1, 2'd2);
    chk("lockup_q", 32'(q), 32'h01);
    chk("lockup_err", 32'(err), 32'h1);
    run(3, 2'd1);
    step(1'b0, 1'b0, 2'd0, 8'h00);
    chk("err_sticky", 32'(err), 32'h1);
    step(1'b1, 1'b0, 2'd0, 8'h00);
    chk("err_cleared", 32'(err), 32'h0);

    // en low mid-rotate freezes everything
    run(4, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd1, 8'h00);
    chk("frozen_q", 32'(q), 32'h10);
    chk("frozen_cycles", 32'(cycles), 32'd4);
    run(4, 2'd1);
    chk("gap_pulse", 32'(period_ok), 32'h1);

    // LSR mid-rotate with en high
    step(1'b1, 1'b0, 2'd0, 8'h00);
    run(5, 2'd1);
    step(1'b1, 1'b1, 2'd1, 8'h00);
    chk("mid_reset_q", 32'(q), 32'h01);
    chk("mid_reset_pulse", 32'(period_ok), 32'h0);
    pulses = 0;
    run(8, 2'd1);
    chk("post_reset_pulse", 32'(pulses), 32'd1);

    // Randomized traffic with sticky modes so rotate periods complete
    rm = 2'd1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rm = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), rm,
           ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
